mac_tap_sequencer: RTL and testbench

- Initiator side of the pipelined MAC interface.
- Accepts 3x3 pixel windows over a valid/ready handshake and holds a 9-entry kernel weight file.
- Drives pixel/weight/accumulator operands into one external 3-stage MAC and collects its results.
- Interleaves MAC_LAT independent windows round-robin so the MAC feedback path is fully used; completed sums leave through a back-pressured result FIFO.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/mac_result_fifo.sv | 63 ++++++
 rtl/mac_tap_sequencer.sv | 178 +++++++++++++++++
 tb/tb_mac_tap_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg : shared sizes and slot-state type for the 3x3 convolution MAC path
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package conv_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int ACC_WIDTH   = 2 * DATA_WIDTH + 1;
    localparam int KERNEL_TAPS = 9;
    localparam int MAC_LAT     = 3;
    localparam int TAP_W       = 4;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_RUN   = 1'b1
    } slot_state_t;
endpackage

`default_nettype wire

// File: rtl/mac_result_fifo.sv
// ----------------------------------------------------------------------------
// mac_result_fifo : synchronous FIFO for finished convolution sums
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full     = (count == CNT_W'(DEPTH));
        empty    = (count == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        // An empty FIFO presents zero rather than a stale entry.
        pop_data = empty ? '0 : mem[rd_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_W'(1);
            end
            if (do_pop) begin
                rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IDX_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end
endmodule

`default_nettype wire

// File: rtl/mac_tap_sequencer.sv
// ----------------------------------------------------------------------------
// mac_tap_sequencer : round-robin 3x3 window sequencer feeding an external MAC
// Optional ReLU on results: define MAC_TAP_SEQ_RELU_EN.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_tap_sequencer #(
    parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
    parameter int MAC_LAT    = conv_pkg::MAC_LAT,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wt_we,
    input  logic [3:0]                wt_addr,
    input  logic [DATA_WIDTH-1:0]     wt_data,
    output logic                      wt_busy,
    input  logic                      win_valid,
    output logic                      win_ready,
    input  logic [9*DATA_WIDTH-1:0]   win_data,
    output logic [DATA_WIDTH-1:0]     mac_pixel,
    output logic [DATA_WIDTH-1:0]     mac_weight,
    output logic [2*DATA_WIDTH:0]     mac_acc,
    input  logic [2*DATA_WIDTH:0]     mac_result,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*DATA_WIDTH:0]     res_data
);
    import conv_pkg::KERNEL_TAPS;
    import conv_pkg::TAP_W;
    import conv_pkg::slot_state_t;
    import conv_pkg::SLOT_EMPTY;
    import conv_pkg::SLOT_RUN;

    localparam int ACC_W = 2 * DATA_WIDTH + 1;
    localparam int PTR_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam int CRD_W = $clog2(OUT_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAC_LAT - 1);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(KERNEL_TAPS - 1);

    slot_state_t           slot_state     [MAC_LAT];
    slot_state_t           slot_state_nxt [MAC_LAT];
    logic [TAP_W-1:0]      slot_tap       [MAC_LAT];
    logic [TAP_W-1:0]      slot_tap_nxt   [MAC_LAT];
    logic [DATA_WIDTH-1:0] slot_win       [MAC_LAT][KERNEL_TAPS];
    logic [DATA_WIDTH-1:0] weights        [KERNEL_TAPS];

    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      ptr_next;
    logic [CRD_W-1:0]      credits;
    logic [MAC_LAT-1:0]    last_sr;

    logic                  issue;
    logic                  issue_last;
    logic                  accept;
    logic                  pop;
    logic                  run_any;
    logic                  ahead_run;
    logic [TAP_W-1:0]      ahead_tap;
    logic [DATA_WIDTH-1:0] pixel_ahead;
    logic [DATA_WIDTH-1:0] weight_ahead;

    logic                  fifo_push;
    logic [ACC_W-1:0]      fifo_push_data;
    logic                  fifo_full;
    logic                  fifo_empty;

    always_comb begin
        ptr_next   = (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
        issue      = (slot_state[ptr] == SLOT_RUN);
        issue_last = issue && (slot_tap[ptr] == LAST_TAP);
        win_ready  = !rst && (slot_state[ptr] == SLOT_EMPTY) && (credits != '0);
        accept     = win_valid && win_ready;
        res_valid  = !fifo_empty;
        pop        = res_valid && res_ready;
        // Tap 0 starts a fresh sum; later taps chain this slot's own partial sum.
        mac_acc    = (issue && (slot_tap[ptr] != '0)) ? mac_result : '0;
    end

    always_comb begin
        run_any = 1'b0;
        for (int i = 0; i < MAC_LAT; i++) begin
            slot_state_nxt[i] = slot_state[i];
            slot_tap_nxt[i]   = slot_tap[i];
            run_any           = run_any | (slot_state[i] == SLOT_RUN);
        end
        if (accept) begin
            slot_state_nxt[ptr] = SLOT_RUN;
            slot_tap_nxt[ptr]   = '0;
        end else if (issue_last) begin
            slot_state_nxt[ptr] = SLOT_EMPTY;
            slot_tap_nxt[ptr]   = '0;
        end else if (issue) begin
            slot_tap_nxt[ptr]   = slot_tap[ptr] + TAP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAC_LAT; i++) begin
                slot_state[i] <= SLOT_EMPTY;
                slot_tap[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < MAC_LAT; i++) begin
                slot_state[i] <= slot_state_nxt[i];
                slot_tap[i]   <= slot_tap_nxt[i];
            end
        end
    end

    // Operands are registered one cycle ahead from the slot the pointer visits
    // next; that slot cannot change state in between since only the current
    // pointer slot is ever updated.
    always_comb begin
        ahead_run    = (slot_state[ptr_next] == SLOT_RUN);
        ahead_tap    = slot_tap[ptr_next];
        pixel_ahead  = ahead_run ? slot_win[ptr_next][ahead_tap] : '0;
        weight_ahead = ahead_run ? weights[ahead_tap] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            mac_pixel  <= '0;
            mac_weight <= '0;
            last_sr    <= '0;
            credits    <= CRD_W'(OUT_DEPTH);
        end else begin
            ptr        <= ptr_next;
            mac_pixel  <= pixel_ahead;
            mac_weight <= weight_ahead;
            last_sr    <= {last_sr[MAC_LAT-2:0], issue_last};
            credits    <= credits - CRD_W'(accept) + CRD_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                slot_win[ptr][k] <= win_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wt_we && (wt_addr < 4'(KERNEL_TAPS)) && !wt_busy) begin
            weights[wt_addr] <= wt_data;
        end
    end

    always_comb begin
        wt_busy   = run_any || (|last_sr) || !fifo_empty;
        // The FIFO slot was reserved at accept time, so full never blocks here.
        fifo_push = last_sr[MAC_LAT-1] && !fifo_full;
`ifdef MAC_TAP_SEQ_RELU_EN
        fifo_push_data = mac_result[ACC_W-1] ? '0 : mac_result;
`else
        fifo_push_data = mac_result;
`endif
    end

    mac_result_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (pop),
        .pop_data  (res_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

`default_nettype wire

// File: tb/tb_mac_tap_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mac_tap_sequencer : directed bench with a behavioural 3-stage MAC attached
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mac_tap_sequencer;
    localparam int DW = 16;
    localparam int AW = 2 * DW + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              wt_we;
    logic [3:0]        wt_addr;
    logic [DW-1:0]     wt_data;
    logic              wt_busy;
    logic              win_valid;
    logic              win_ready;
    logic [9*DW-1:0]   win_data;
    logic [DW-1:0]     mac_pixel;
    logic [DW-1:0]     mac_weight;
    logic [AW-1:0]     mac_acc;
    logic [AW-1:0]     mac_result;
    logic              res_valid;
    logic              res_ready;
    logic [AW-1:0]     res_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_tap_sequencer #(
        .DATA_WIDTH (DW),
        .MAC_LAT    (3),
        .OUT_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wt_we      (wt_we),
        .wt_addr    (wt_addr),
        .wt_data    (wt_data),
        .wt_busy    (wt_busy),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .mac_pixel  (mac_pixel),
        .mac_weight (mac_weight),
        .mac_acc    (mac_acc),
        .mac_result (mac_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
    );

    // External MAC: result = pixel*weight + acc, three register stages, no reset.
    logic signed [AW-1:0] m1, m2, m3;

    function automatic logic signed [AW-1:0] mac_op(input logic [DW-1:0] p,
                                                    input logic [DW-1:0] w,
                                                    input logic [AW-1:0] a);
        logic signed [AW-1:0] sp, sw, sa;
        sp = $signed(p);
        sw = $signed(w);
        sa = $signed(a);
        return sp * sw + sa;
    endfunction

    always @(posedge clk) begin
        m1 <= mac_op(mac_pixel, mac_weight, mac_acc);
        m2 <= m1;
        m3 <= m2;
    end
    assign mac_result = m3;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [9*DW-1:0] win_fill(input int v);
        logic [9*DW-1:0] w;
        for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(v);
        return w;
    endfunction

    task automatic write_wt(input int addr, input int data);
        wt_we   = 1'b1;
        wt_addr = 4'(addr);
        wt_data = DW'(data);
        step();
        wt_we   = 1'b0;
    endtask

    task automatic fill_wts(input int v);
        for (int i = 0; i < 9; i++) write_wt(i, v);
    endtask

    task automatic offer(input string tag, input logic [9*DW-1:0] w);
        win_data  = w;
        win_valid = 1'b1;
        chk(tag, {32'd0, win_ready}, 33'd1);
        step();
        win_valid = 1'b0;
    endtask

    // Called one cycle after the accept; returns the cycle count since accept.
    task automatic take_result(output logic [AW-1:0] d, output int lat);
        lat = 1;
        while (!res_valid && lat < 100) begin
            step();
            lat++;
        end
        if (!res_valid) chk("result_timeout", {32'd0, res_valid}, 33'd1);
        d = res_data;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin : main
        logic [AW-1:0]   d;
        logic [AW-1:0]   exp;
        logic [9*DW-1:0] w;
        logic [9*DW-1:0] pk [6];
        logic [AW-1:0]   got_d [6];
        int              rc [3];
        int              lat;
        int              got;
        int              nxt;
        int              cyc;

        rst = 1'b1; wt_we = 1'b0; wt_addr = '0; wt_data = '0;
        win_valid = 1'b0; win_data = '0; res_ready = 1'b0;
        #2;
        chk("rst_win_ready", {32'd0, win_ready}, 33'd0);
        chk("rst_res_valid", {32'd0, res_valid}, 33'd0);
        chk("rst_wt_busy",   {32'd0, wt_busy},   33'd0);
        chk("rst_mac_acc",   mac_acc,            33'd0);
        chk("rst_res_data",  res_data,           33'd0);
        step(); step();
        rst = 1'b0;
        step();
        chk("post_rst_ready", {32'd0, win_ready}, 33'd1);

        // Weights 1, window 1..9 -> 45 with 31-cycle latency
        fill_wts(1);
        for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(k + 1);
        offer("t1_ready", w);
        chk("t1_busy", {32'd0, wt_busy}, 33'd1);
        take_result(d, lat);
        chk("t1_latency", AW'(lat), 33'd31);
        chk("t1_sum", d, 33'd45);
        chk("t1_drained", {32'd0, res_valid}, 33'd0);

        // Single nonzero tap with a negative pixel
        fill_wts(0);
        write_wt(4, 7);
        w = win_fill(11);
        w[4*DW +: DW] = -16'sd300;
        offer("t2_ready", w);
        take_result(d, lat);
`ifdef MAC_TAP_SEQ_RELU_EN
        exp = 33'd0;
`else
        exp = -33'sd2100;
`endif
        chk("t2_sum", d, exp);

        // All weights 100, all pixels -5
        fill_wts(100);
        offer("t3_ready", win_fill(-5));
        take_result(d, lat);
`ifdef MAC_TAP_SEQ_RELU_EN
        exp = 33'd0;
`else
        exp = -33'sd4500;
`endif
        chk("t3_sum", d, exp);

        // Three back-to-back windows, consumer always ready
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) offer("t4_ready", win_fill(i + 1));
        res_ready = 1'b1;
        cyc = 3;
        got = 0;
        while (got < 3 && cyc < 80) begin
            if (res_valid) begin
                chk("t4_sum", res_data, AW'(900 * (got + 1)));
                rc[got] = cyc;
                got++;
            end
            step();
            cyc++;
        end
        res_ready = 1'b0;
        chk("t4_count", AW'(got), 33'd3);
        chk("t4_first", AW'(rc[0]), 33'd31);
        chk("t4_second", AW'(rc[1]), 33'd32);
        chk("t4_third", AW'(rc[2]), 33'd33);

        // Back-pressure: only OUT_DEPTH windows get in while results sit unread
        for (int i = 0; i < 6; i++) pk[i] = win_fill(i + 1);
        nxt = 0;
        for (int c = 0; c < 80; c++) begin
            win_valid = (nxt < 6);
            win_data  = pk[(nxt < 6) ? nxt : 0];
            if (win_valid && win_ready) nxt++;
            step();
        end
        win_valid = 1'b0;
        chk("t5_accepted", AW'(nxt), 33'd4);
        chk("t5_ready_low", {32'd0, win_ready}, 33'd0);
        chk("t5_res_valid", {32'd0, res_valid}, 33'd1);
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 160 && got < 6; c++) begin
            if (res_valid) begin
                got_d[got] = res_data;
                got++;
            end
            win_valid = (nxt < 6);
            win_data  = pk[(nxt < 6) ? nxt : 0];
            if (win_valid && win_ready) nxt++;
            step();
        end
        win_valid = 1'b0;
        step(); step(); step();
        chk("t5_total_accepted", AW'(nxt), 33'd6);
        chk("t5_total_results", AW'(got), 33'd6);
        for (int i = 0; i < 6; i++) chk("t5_sum", got_d[i], AW'(900 * (i + 1)));
        chk("t5_no_extra", {32'd0, res_valid}, 33'd0);
        chk("t5_idle", {32'd0, wt_busy}, 33'd0);
        res_ready = 1'b0;

        // Reset with two slots running; dropped weight write while busy
        offer("t6_ready_a", win_fill(1));
        offer("t6_ready_b", win_fill(2));
        step(); step(); step(); step();
        chk("t6_busy", {32'd0, wt_busy}, 33'd1);
        write_wt(0, 999);
        rst = 1'b1;
        #1;
        chk("t6_rst_pixel",  {17'd0, mac_pixel},  33'd0);
        chk("t6_rst_weight", {17'd0, mac_weight}, 33'd0);
        chk("t6_rst_acc",    mac_acc,             33'd0);
        chk("t6_rst_ready",  {32'd0, win_ready},  33'd0);
        chk("t6_rst_valid",  {32'd0, res_valid},  33'd0);
        chk("t6_rst_data",   res_data,            33'd0);
        chk("t6_rst_busy",   {32'd0, wt_busy},    33'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        offer("t6_ready_c", win_fill(1));
        take_result(d, lat);
        chk("t6_latency", AW'(lat), 33'd31);
        chk("t6_sum", d, 33'd900);
        step(); step(); step(); step();
        chk("t6_no_stale", {32'd0, res_valid}, 33'd0);
        chk("t6_idle", {32'd0, wt_busy}, 33'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
